// File: rtl/fifo_rd_port.sv
// Read-side controller of the asynchronous FIFO. It owns the read pointer, synchronizes the
// write-side Gray pointer, derives empty/level and presents popped words on a valid/ready stage.
module fifo_rd_port #(
   parameter int Data_Width = 8,
   parameter int Addr_Width = 8
) (
   input  logic                  rd_clk,
   input  logic                  rd_rstn,
   input  logic [Addr_Width:0]   wr_ptr_gray,
   input  logic [Data_Width-1:0] mem_data,
   input  logic                  dout_ready,
   output logic [Addr_Width:0]   rd_addr,
   output logic [Addr_Width:0]   rd_ptr_gray,
   output logic                  rd_en,
   output logic                  empty,
   output logic [Addr_Width:0]   level,
   output logic [Data_Width-1:0] dout,
   output logic                  dout_valid
);

   localparam int Ptr_Width = Addr_Width + 1;

   logic [Addr_Width:0] wq1;
   logic [Addr_Width:0] wq2;
   logic [Addr_Width:0] rd_bin;
   logic [Addr_Width:0] next_bin;
   logic [Addr_Width:0] next_gray;
   logic [Addr_Width:0] wr_bin_sync;
   logic                pop;

   function automatic logic [Addr_Width:0] gray2bin(input logic [Addr_Width:0] g);
      logic [Addr_Width:0] b;
      b[Addr_Width] = g[Addr_Width];
      for (int i = Addr_Width - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // A held word blocks the pop until downstream takes it, so dout never changes under stall.
   assign pop         = !empty && (!dout_valid || dout_ready);
   assign rd_en       = pop;
   assign next_bin    = rd_bin + Ptr_Width'(pop);
   assign next_gray   = next_bin ^ (next_bin >> 1);
   assign wr_bin_sync = gray2bin(wq2);
   assign level       = wr_bin_sync - rd_bin;
   assign rd_addr     = rd_bin;

   always_ff @(posedge rd_clk or negedge rd_rstn) begin
      if (!rd_rstn) begin
         wq1         <= '0;
         wq2         <= '0;
         rd_bin      <= '0;
         rd_ptr_gray <= '0;
         empty       <= 1'b1;
         dout        <= '0;
         dout_valid  <= 1'b0;
      end else begin
         wq1         <= wr_ptr_gray;
         wq2         <= wq1;
         rd_bin      <= next_bin;
         rd_ptr_gray <= next_gray;
         // Compared against the synchronized pointer, so empty can only lag a write.
         empty       <= (next_gray == wq2);
         if (pop) begin
            dout       <= mem_data;
            dout_valid <= 1'b1;
         end else if (dout_ready) begin
            dout_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/fifo_rd_port.md
# fifo_rd_port

Read-side controller for the asynchronous FIFO, running entirely in the read clock domain. It owns the read pointer (binary and Gray) and synchronizes the write-domain Gray pointer into the read domain. It derives `empty` and an occupancy level, and drives the FIFO memory read address. Popped words are presented through a registered valid/ready output stage. The Gray read pointer it exports is consumed by the write-side full logic.

## Interface
Parameters:
- `Data_Width`, 8: word width.
- `Addr_Width`, 8: memory address bits. Pointers are `Addr_Width+1` bits; depth is `2**Addr_Width`.

Ports:
- `rd_clk`  in  1  read clock; the only clock in this block.
- `rd_rstn`  in  1  reset, asynchronous assert, active-low.
- `wr_ptr_gray`  in  Addr_Width+1  write pointer, Gray coded, from the write domain (asynchronous to `rd_clk`).
- `mem_data`  in  Data_Width  combinational memory output at `rd_addr`.
- `dout_ready`  in  1  downstream accepts `dout` this cycle.
- `rd_addr`  out  Addr_Width+1  binary read pointer to memory; the low `Addr_Width` bits index memory.
- `rd_ptr_gray`  out  Addr_Width+1  registered Gray read pointer, to the write-domain synchronizer.
- `rd_en`  out  1  pop strobe; high in the cycle a word is taken from memory.
- `empty`  out  1  registered empty flag.
- `level`  out  Addr_Width+1  read-domain occupancy estimate.
- `dout`  out  Data_Width  output word.
- `dout_valid`  out  1  `dout` holds an unconsumed word.

## Operation
- Synchronizer:
  - two flops, `wq1 <= wr_ptr_gray`, then `wq2 <= wq1`.
  - No other logic samples `wr_ptr_gray`.
- Pop condition:
  - `pop = !empty && (!dout_valid || dout_ready)`.
  - `rd_en = pop`, combinational.
- On pop:
  - `dout <= mem_data`, `dout_valid <= 1`.
  - `rd_bin <= rd_bin + 1`, modulo `2**(Addr_Width+1)`.
  - `rd_ptr_gray <= next_bin ^ (next_bin >> 1)`.
- Without pop:
  - if `dout_valid && dout_ready`, then `dout_valid <= 0`.
  - Otherwise the output stage holds.
  - `dout` is never changed while `dout_valid && !dout_ready`.
- Empty flag:
  - `empty <= (gray(next_bin) == wq2)`, where `next_bin` is `rd_bin+pop`.
  - Empty is registered and pessimistic: it may lag a write but never reports data that is not yet written.
- Level:
  - `level = gray2bin(wq2) - rd_bin`, modulo `2**(Addr_Width+1)`, combinational from registers.
  - Range is 0 to `2**Addr_Width`.
  - `level` counts words still in memory and excludes the word held in `dout`.
- Wrap-around:
  - The pointer MSB toggles on every full lap.
  - `rd_addr[Addr_Width-1:0]` wraps from `2**Addr_Width-1` to 0.
- Simultaneous events:
  - `dout_ready` while `dout_valid` and not empty: consume and refill in the same edge, with `dout_valid` staying 1.
  - `dout_ready` while empty: `dout_valid` falls.
- Reset (asynchronous, any time, including mid-stream) sets:
  - `rd_bin`, `rd_ptr_gray`, `wq1`, `wq2` to 0;
  - `empty` to 1;
  - `dout_valid` and `dout` to 0.
  - `rd_en` is then 0 because `empty` is 1.
  - On reset release, no pop occurs until the synchronized write pointer differs from 0.

## Timing
- Write-pointer latency:
  - `wr_ptr_gray` changes before `rd_clk` edge E1.
  - `wq2` updates at E2.
  - `empty` falls after E3.
  - Pop occurs at E4, with `dout_valid=1` after E4.
  - Worst case is 4 edges.
- Read-pointer update: `rd_ptr_gray` updates at the pop edge, with no extra delay.
- Throughput: with `dout_ready` held at 1 and data available, one word per cycle, back-to-back.
- Backpressure: when `dout_ready=0` and `dout_valid=1`, `rd_en` is 0 and the pointers hold.
- Last word: when the pop takes the last word, `empty` rises at the same edge as the pop.

## Test plan
- Reset:
  - Assert `rd_rstn=0` mid-stream with `dout_valid=1`.
  - Required: `empty=1`, `dout_valid=0`, `dout=0`, `rd_addr=0`, `rd_ptr_gray=0` immediately, without waiting for a clock edge.
- Single word:
  - `wr_ptr_gray` 0→1, `mem_data=0xA5`, `dout_ready=0`.
  - Required: `empty` falls after E3; `dout=0xA5` and `dout_valid=1` after E4; `rd_addr=1`; `rd_ptr_gray=1`; `empty=1` after E4; `level=0`.
- Backpressure:
  - Write 3 words, hold `dout_ready=0` for 10 cycles.
  - Required: `dout` stable, `rd_en=0`, `level=2`.
  - Release `dout_ready=1`: required three consecutive distinct words, then `dout_valid=0`.
- Streaming:
  - 16 words pre-written, `dout_ready=1`.
  - Required: 16 pops on 16 consecutive edges, `rd_addr` 0→16, in-order data.
- Wrap:
  - Preload the pointers to 255 with 2 words available.
  - Required: `rd_addr` 255→256, memory index 0, `rd_ptr_gray=0x180`.
  - Continuing from 511: required `rd_addr` 511→0, `rd_ptr_gray` 0x100→0x000.
- Full level:
  - Synchronized write pointer 256 ahead (`wr_ptr_gray=0x180`, `rd_bin=0`).
  - Required: `level=256`, `empty=0`.
